spi_xfer_control: RTL and testbench

Parametrised SPI transfer controller between the wishbone register side and the SPI sender/receiver shift registers. Replaces single-entry buffer flags with DEPTH-entry TX and RX FIFOs, a sender load FSM, and an edge-detected receive capture path. Adds sticky overflow errors, flush controls and a maskable interrupt. Sits between the wishbone slave and the sender/receiver shifters, which keep their existing handshakes.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sync_fifo.sv | 76 +++++++
 rtl/spi_xfer_control.sv | 162 ++++++++++++++++
 tb/tb_spi_xfer_control.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI transfer controller.
// Bit indices for CONTROL/STATUS and the sender load FSM states.
package spi_pkg;

    localparam int CTL_RX_DIS   = 0;
    localparam int CTL_TX_DIS   = 1;
    localparam int CTL_TXE_IE   = 2;
    localparam int CTL_RXD_IE   = 3;
    localparam int CTL_ERR_IE   = 4;
    localparam int CTL_HALT     = 5;
    localparam int CTL_TX_FLUSH = 6;
    localparam int CTL_RX_FLUSH = 7;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_BUSY     = 6;
    localparam int ST_IRQ      = 7;

    localparam logic [7:0] STATUS_RST = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } snd_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and drop indication.
// Push and pop may coincide when full; flush beats push.
module spi_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  level,
    output logic              drop
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop & ~flush;
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            if (do_push & ~do_pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (do_pop & ~do_push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_xfer_control.sv
// SPI transfer controller: host-side TX/RX FIFOs, sender load FSM,
// edge-detected receive capture, sticky errors and interrupt.
module spi_xfer_control
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [7:0]        CONTROL,
    input  logic              WRITE,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              READ,
    output logic [DATA_W-1:0] RDATA,
    input  logic              STATUS_CLR,
    output logic [7:0]        STATUS,
    output logic [CNT_W-1:0]  TX_LEVEL,
    output logic [CNT_W-1:0]  RX_LEVEL,
    input  logic              SENDER_EMPTY_STATE,
    output logic              SENDER_WRITE,
    output logic [DATA_W-1:0] SENDER_DATA,
    output logic              TE,
    input  logic              RECEIVER_FULL_STATE,
    input  logic [DATA_W-1:0] RECEIVER_DATA,
    output logic              RECEIVER_READ,
    output logic              RE,
    output logic              IRQ
);

    snd_state_e        state_q, state_d;
    logic              te_q, te_d;
    logic              re_q, re_d;
    logic              rfs_q, rfs_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              irq_q, irq_d;

    logic              tx_full, tx_empty, tx_drop, tx_pop;
    logic              rx_full, rx_empty, rx_drop;
    logic [DATA_W-1:0] tx_head;
    logic              snd_write;
    logic              capture;
    logic              busy;

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .clr   (CLR),
        .flush (CONTROL[CTL_TX_FLUSH]),
        .push  (WRITE),
        .pop   (tx_pop),
        .wdata (WDATA),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (TX_LEVEL),
        .drop  (tx_drop)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .clr   (CLR),
        .flush (CONTROL[CTL_RX_FLUSH]),
        .push  (capture),
        .pop   (READ),
        .wdata (RECEIVER_DATA),
        .rdata (RDATA),
        .full  (rx_full),
        .empty (rx_empty),
        .level (RX_LEVEL),
        .drop  (rx_drop)
    );

    // Only a fresh rising edge of the receiver flag is a new frame.
    assign capture       = RECEIVER_FULL_STATE & ~rfs_q & re_q & ~CLR;
    assign RECEIVER_READ = capture;

    always_comb begin
        state_d   = state_q;
        snd_write = 1'b0;
        tx_pop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (te_q & ~tx_empty & SENDER_EMPTY_STATE) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tx_empty) begin
                    state_d = S_IDLE;
                end else begin
                    snd_write = 1'b1;
                    tx_pop    = 1'b1;
                    state_d   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!SENDER_EMPTY_STATE) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (SENDER_EMPTY_STATE) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    assign SENDER_WRITE = snd_write;
    assign SENDER_DATA  = snd_write ? tx_head : '0;
    assign busy         = (state_q != S_IDLE) | ~tx_empty;

    always_comb begin
        te_d     = ~(CONTROL[CTL_TX_DIS] | CONTROL[CTL_HALT]);
        re_d     = ~(CONTROL[CTL_RX_DIS] | CONTROL[CTL_HALT]);
        rfs_d    = RECEIVER_FULL_STATE;
        rx_ovf_d = rx_drop | (rx_ovf_q & ~STATUS_CLR);
        tx_ovf_d = tx_drop | (tx_ovf_q & ~STATUS_CLR);
        irq_d    = (CONTROL[CTL_TXE_IE] & tx_empty)
                 | (CONTROL[CTL_RXD_IE] & ~rx_empty)
                 | (CONTROL[CTL_ERR_IE] & (rx_ovf_q | tx_ovf_q));
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= S_IDLE;
            te_q     <= 1'b0;
            re_q     <= 1'b0;
            rfs_q    <= 1'b1;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            te_q     <= te_d;
            re_q     <= re_d;
            rfs_q    <= rfs_d;
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign TE  = te_q;
    assign RE  = re_q;
    assign IRQ = irq_q;

    always_comb begin
        STATUS              = '0;
        STATUS[ST_TX_FULL]  = tx_full;
        STATUS[ST_TX_EMPTY] = tx_empty;
        STATUS[ST_RX_FULL]  = rx_full;
        STATUS[ST_RX_EMPTY] = rx_empty;
        STATUS[ST_RX_OVF]   = rx_ovf_q;
        STATUS[ST_TX_OVF]   = tx_ovf_q;
        STATUS[ST_BUSY]     = busy;
        STATUS[ST_IRQ]      = irq_q;
    end

endmodule

// File: tb/tb_spi_xfer_control.sv
// Directed bench for spi_xfer_control: vector table for TX FIFO,
// sticky error and IRQ behaviour, plus hand sequences for multi-cycle cases.
module tb_spi_xfer_control;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] CONTROL;
    logic       WRITE;
    logic [7:0] WDATA;
    logic       READ;
    logic [7:0] RDATA;
    logic       STATUS_CLR;
    logic [7:0] STATUS;
    logic [2:0] TX_LEVEL;
    logic [2:0] RX_LEVEL;
    logic       SENDER_EMPTY_STATE;
    logic       SENDER_WRITE;
    logic [7:0] SENDER_DATA;
    logic       TE;
    logic       RECEIVER_FULL_STATE;
    logic [7:0] RECEIVER_DATA;
    logic       RECEIVER_READ;
    logic       RE;
    logic       IRQ;

    int checks = 0;
    int errors = 0;

    spi_xfer_control #(.DATA_W(8), .DEPTH(4)) dut (
        .CLK                 (CLK),
        .CLR                 (CLR),
        .CONTROL             (CONTROL),
        .WRITE               (WRITE),
        .WDATA               (WDATA),
        .READ                (READ),
        .RDATA               (RDATA),
        .STATUS_CLR          (STATUS_CLR),
        .STATUS              (STATUS),
        .TX_LEVEL            (TX_LEVEL),
        .RX_LEVEL            (RX_LEVEL),
        .SENDER_EMPTY_STATE  (SENDER_EMPTY_STATE),
        .SENDER_WRITE        (SENDER_WRITE),
        .SENDER_DATA         (SENDER_DATA),
        .TE                  (TE),
        .RECEIVER_FULL_STATE (RECEIVER_FULL_STATE),
        .RECEIVER_DATA       (RECEIVER_DATA),
        .RECEIVER_READ       (RECEIVER_READ),
        .RE                  (RE),
        .IRQ                 (IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    typedef struct {
        logic [7:0] ctl;
        logic       wr;
        logic [7:0] wd;
        logic       sclr;
        logic [2:0] txl;
        logic [2:0] rxl;
        logic [7:0] st;
        logic       irq;
    } vec_t;

    vec_t vt [11];

    int   wr_cyc [2];
    logic [7:0] wr_dat [2];
    logic [2:0] wr_lvl [2];
    logic       wr_busy [2];
    int   nwr;
    int   busy_at;
    int   idle_at;
    int   pulses;
    logic seen;
    logic [7:0] rd_exp [4];

    initial begin
        vt[0]  = '{8'h12, 1'b1, 8'hA0, 1'b0, 3'd1, 3'd0, 8'h48, 1'b0};
        vt[1]  = '{8'h12, 1'b1, 8'hA1, 1'b0, 3'd2, 3'd0, 8'h48, 1'b0};
        vt[2]  = '{8'h12, 1'b1, 8'hA2, 1'b0, 3'd3, 3'd0, 8'h48, 1'b0};
        vt[3]  = '{8'h12, 1'b1, 8'hA3, 1'b0, 3'd4, 3'd0, 8'h49, 1'b0};
        vt[4]  = '{8'h12, 1'b1, 8'hA4, 1'b0, 3'd4, 3'd0, 8'h69, 1'b0};
        vt[5]  = '{8'h12, 1'b0, 8'h00, 1'b0, 3'd4, 3'd0, 8'hE9, 1'b1};
        vt[6]  = '{8'h12, 1'b0, 8'h00, 1'b1, 3'd4, 3'd0, 8'hC9, 1'b1};
        vt[7]  = '{8'h12, 1'b0, 8'h00, 1'b0, 3'd4, 3'd0, 8'h49, 1'b0};
        vt[8]  = '{8'h12, 1'b1, 8'hA5, 1'b1, 3'd4, 3'd0, 8'h69, 1'b0};
        vt[9]  = '{8'h52, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 8'hAA, 1'b1};
        vt[10] = '{8'h02, 1'b0, 8'h00, 1'b1, 3'd0, 3'd0, 8'h0A, 1'b0};

        CLR = 1'b1;
        CONTROL = 8'h00;
        WRITE = 1'b0;
        WDATA = 8'h00;
        READ = 1'b0;
        STATUS_CLR = 1'b0;
        SENDER_EMPTY_STATE = 1'b1;
        RECEIVER_FULL_STATE = 1'b0;
        RECEIVER_DATA = 8'h00;

        // Reset state
        cyc();
        cyc();
        chk("rst_status", STATUS, 8'h0A);
        chk("rst_te", TE, 0);
        chk("rst_re", RE, 0);
        chk("rst_irq", IRQ, 0);
        chk("rst_txl", TX_LEVEL, 0);
        chk("rst_rxl", RX_LEVEL, 0);
        chk("rst_swr", SENDER_WRITE, 0);
        chk("rst_sdata", SENDER_DATA, 0);
        chk("rst_rrd", RECEIVER_READ, 0);
        chk("rst_rdata", RDATA, 0);
        CLR = 1'b0;
        cyc();
        chk("te_after_rst", TE, 1);
        chk("re_after_rst", RE, 1);
        chk("status_after_rst", STATUS, 8'h0A);

        // Table: TX fill, overflow, sticky clear, IRQ latency, flush
        for (int i = 0; i < 11; i++) begin
            CONTROL    = vt[i].ctl;
            WRITE      = vt[i].wr;
            WDATA      = vt[i].wd;
            STATUS_CLR = vt[i].sclr;
            cyc();
            chk($sformatf("vec%0d_txl", i), TX_LEVEL, vt[i].txl);
            chk($sformatf("vec%0d_rxl", i), RX_LEVEL, vt[i].rxl);
            chk($sformatf("vec%0d_status", i), STATUS, vt[i].st);
            chk($sformatf("vec%0d_irq", i), IRQ, vt[i].irq);
        end
        WRITE = 1'b0;
        STATUS_CLR = 1'b0;
        CONTROL = 8'h00;
        cyc();

        // Sender: two frames with a modelled shifter
        nwr = 0;
        busy_at = -1;
        idle_at = -1;
        for (int j = 0; j < 40; j++) begin
            if (SENDER_WRITE) begin
                if (nwr < 2) begin
                    wr_cyc[nwr]  = j;
                    wr_dat[nwr]  = SENDER_DATA;
                    wr_lvl[nwr]  = TX_LEVEL;
                    wr_busy[nwr] = STATUS[6];
                end
                nwr++;
                busy_at = j + 2;
                idle_at = j + 10;
            end
            if (j == busy_at) SENDER_EMPTY_STATE = 1'b0;
            if (j == idle_at) SENDER_EMPTY_STATE = 1'b1;
            WRITE = (j < 2);
            WDATA = (j == 0) ? 8'hA5 : 8'h3C;
            cyc();
        end
        WRITE = 1'b0;
        chk("snd_count", nwr, 2);
        if (nwr >= 2) begin
            chk("snd_data0", wr_dat[0], 8'hA5);
            chk("snd_data1", wr_dat[1], 8'h3C);
            chk("snd_lvl0", wr_lvl[0], 2);
            chk("snd_lvl1", wr_lvl[1], 1);
            chk("snd_busy1", wr_busy[1], 1);
            chk("snd_gap_ge2", (wr_cyc[1] - wr_cyc[0] - 1) >= 2, 1);
        end
        chk("snd_lvl_end", TX_LEVEL, 0);
        chk("snd_busy_end", STATUS[6], 0);

        // Receive: 5 frames into a 4-deep FIFO
        pulses = 0;
        for (int f = 1; f <= 5; f++) begin
            RECEIVER_DATA = 8'(f);
            RECEIVER_FULL_STATE = 1'b1;
            #1;
            if (RECEIVER_READ) pulses++;
            cyc();
            RECEIVER_FULL_STATE = 1'b0;
            cyc();
        end
        chk("rx_pulses", pulses, 5);
        chk("rx_lvl_full", RX_LEVEL, 4);
        chk("rx_full_bit", STATUS[2], 1);
        chk("rx_ovf_bit", STATUS[4], 1);
        chk("rx_head", RDATA, 8'h01);
        STATUS_CLR = 1'b1;
        cyc();
        STATUS_CLR = 1'b0;
        chk("rx_ovf_clr", STATUS[4], 0);

        // Capture and pop in the same cycle while full
        RECEIVER_DATA = 8'h06;
        RECEIVER_FULL_STATE = 1'b1;
        READ = 1'b1;
        #1;
        chk("rx_full_ack", RECEIVER_READ, 1);
        cyc();
        RECEIVER_FULL_STATE = 1'b0;
        READ = 1'b0;
        chk("rx_pp_lvl", RX_LEVEL, 4);
        chk("rx_pp_ovf", STATUS[4], 0);
        rd_exp[0] = 8'h02;
        rd_exp[1] = 8'h03;
        rd_exp[2] = 8'h04;
        rd_exp[3] = 8'h06;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rx_read%0d", k), RDATA, rd_exp[k]);
            READ = 1'b1;
            cyc();
            READ = 1'b0;
        end
        chk("rx_lvl_drained", RX_LEVEL, 0);
        chk("rx_rdata_empty", RDATA, 0);
        READ = 1'b1;
        cyc();
        READ = 1'b0;
        chk("rx_read_empty_lvl", RX_LEVEL, 0);
        chk("rx_read_empty_st", STATUS, 8'h0A);

        // Halt blocks capture; held-high flag is not a new edge
        CONTROL = 8'h20;
        cyc();
        chk("halt_te", TE, 0);
        chk("halt_re", RE, 0);
        RECEIVER_DATA = 8'h55;
        RECEIVER_FULL_STATE = 1'b1;
        #1;
        chk("halt_no_ack", RECEIVER_READ, 0);
        cyc();
        CONTROL = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("held_no_ack%0d", k), RECEIVER_READ, 0);
        end
        chk("held_re", RE, 1);
        chk("held_lvl", RX_LEVEL, 0);
        RECEIVER_FULL_STATE = 1'b0;
        cyc();
        RECEIVER_DATA = 8'h77;
        RECEIVER_FULL_STATE = 1'b1;
        #1;
        chk("edge_ack", RECEIVER_READ, 1);
        cyc();
        RECEIVER_FULL_STATE = 1'b0;
        chk("edge_lvl", RX_LEVEL, 1);
        chk("edge_rdata", RDATA, 8'h77);
        CONTROL = 8'h80;
        cyc();
        CONTROL = 8'h00;
        chk("rx_flush_lvl", RX_LEVEL, 0);
        chk("rx_flush_empty", STATUS[3], 1);

        // Reset while the FSM waits for the shifter
        CONTROL = 8'h02;
        for (int k = 0; k < 4; k++) begin
            WRITE = 1'b1;
            WDATA = 8'hB0 + 8'(k);
            cyc();
        end
        WRITE = 1'b0;
        CONTROL = 8'h00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc();
            if (SENDER_WRITE) begin
                seen = 1'b1;
                chk("clr_load_data", SENDER_DATA, 8'hB0);
            end
        end
        chk("clr_load_seen", seen, 1);
        cyc();
        chk("wait_busy_lvl", TX_LEVEL, 3);
        chk("wait_busy_busy", STATUS[6], 1);
        CLR = 1'b1;
        cyc();
        chk("clr_txl", TX_LEVEL, 0);
        chk("clr_swr", SENDER_WRITE, 0);
        chk("clr_status", STATUS, 8'h0A);
        chk("clr_te", TE, 0);
        CLR = 1'b0;
        cyc();
        chk("post_clr_idle", STATUS[6], 0);
        chk("post_clr_swr", SENDER_WRITE, 0);
        chk("post_clr_te", TE, 1);

        // TX flush while full
        CONTROL = 8'h02;
        for (int k = 0; k < 4; k++) begin
            WRITE = 1'b1;
            WDATA = 8'hC0 + 8'(k);
            cyc();
        end
        WRITE = 1'b0;
        chk("txf_full_lvl", TX_LEVEL, 4);
        chk("txf_full_bit", STATUS[0], 1);
        CONTROL = 8'h42;
        cyc();
        CONTROL = 8'h02;
        chk("txf_lvl", TX_LEVEL, 0);
        chk("txf_empty", STATUS[1], 1);
        chk("txf_not_full", STATUS[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
